// File: rtl/ftdi_frame_rx.sv
// FT232H 245-sync FIFO read front end: header hunt, RGB888 pixel assembly and
// back-buffer writes, with a read stall until the scan side acknowledges the swap.
module ftdi_frame_rx #(
   parameter int unsigned COLS     = 64,
   parameter int unsigned ROWS     = 64,
   parameter int unsigned ADDR_W   = 12,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        ftdi_data,
   input  logic              ftdi_rxf_n,
   output logic              ftdi_rd_n,
   output logic              ftdi_oe_n,
   input  logic              swap_ack,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [23:0]       fb_data,
   output logic              frame_done,
   output logic              frame_pending,
   output logic [7:0]        hdr_err_cnt
);

   typedef enum logic [1:0] {RD_IDLE, RD_OE, RD_READ} rd_state_e;
   typedef enum logic       {PS_HDR, PS_PIX}          ps_state_e;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(COLS * ROWS - 1);

   rd_state_e         rd_state_q, rd_state_d;
   logic              oe_n_q, oe_n_d;
   logic              rd_n_q, rd_n_d;
   logic [7:0]        byte_q, byte_d;
   logic              byte_v_q, byte_v_d;
   ps_state_e         ps_q, ps_d;
   logic [1:0]        sel_q, sel_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [7:0]        r_q, r_d;
   logic [7:0]        g_q, g_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [23:0]       fb_data_q, fb_data_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_pending_q, frame_pending_d;
   logic [7:0]        hdr_err_q, hdr_err_d;
   logic              stop;

   // Final B byte is sitting in byte_q: drop rd_n on this edge so at most one
   // further byte can follow it.
   assign stop = byte_v_q && (ps_q == PS_PIX) && (sel_q == 2'd2) && (pix_cnt_q == LAST_PIX);

   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE: if (!ftdi_rxf_n && !frame_pending_q && !stop) rd_state_d = RD_OE;
         RD_OE:   rd_state_d = RD_READ;
         RD_READ: if (ftdi_rxf_n || stop) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
      oe_n_d = (rd_state_d == RD_IDLE);
      rd_n_d = (rd_state_d != RD_READ);

      byte_v_d = !rd_n_q && !ftdi_rxf_n;
      byte_d   = byte_v_d ? ftdi_data : byte_q;
   end

   always_comb begin
      ps_d            = ps_q;
      sel_d           = sel_q;
      pix_cnt_d       = pix_cnt_q;
      r_d             = r_q;
      g_d             = g_q;
      fb_we_d         = 1'b0;
      fb_addr_d       = fb_addr_q;
      fb_data_d       = fb_data_q;
      frame_done_d    = 1'b0;
      hdr_err_d       = hdr_err_q;

      if (byte_v_q) begin
         if (ps_q == PS_HDR) begin
            if (byte_q == HDR_BYTE) begin
               ps_d      = PS_PIX;
               pix_cnt_d = '0;
               sel_d     = 2'd0;
            end else if (hdr_err_q != 8'hFF) begin
               hdr_err_d = hdr_err_q + 8'd1;
            end
         end else begin
            case (sel_q)
               2'd0: begin
                  r_d   = byte_q;
                  sel_d = 2'd1;
               end
               2'd1: begin
                  g_d   = byte_q;
                  sel_d = 2'd2;
               end
               default: begin
                  fb_we_d   = 1'b1;
                  fb_addr_d = pix_cnt_q;
                  fb_data_d = {r_q, g_q, byte_q};
                  pix_cnt_d = pix_cnt_q + 1'b1;
                  sel_d     = 2'd0;
                  if (pix_cnt_q == LAST_PIX) begin
                     frame_done_d = 1'b1;
                     ps_d         = PS_HDR;
                  end
               end
            endcase
         end
      end

      // A completion in the same cycle as swap_ack keeps the buffer pending.
      frame_pending_d = frame_done_d || (frame_pending_q && !swap_ack);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q      <= RD_IDLE;
         oe_n_q          <= 1'b1;
         rd_n_q          <= 1'b1;
         byte_q          <= '0;
         byte_v_q        <= 1'b0;
         ps_q            <= PS_HDR;
         sel_q           <= '0;
         pix_cnt_q       <= '0;
         r_q             <= '0;
         g_q             <= '0;
         fb_we_q         <= 1'b0;
         fb_addr_q       <= '0;
         fb_data_q       <= '0;
         frame_done_q    <= 1'b0;
         frame_pending_q <= 1'b0;
         hdr_err_q       <= '0;
      end else begin
         rd_state_q      <= rd_state_d;
         oe_n_q          <= oe_n_d;
         rd_n_q          <= rd_n_d;
         byte_q          <= byte_d;
         byte_v_q        <= byte_v_d;
         ps_q            <= ps_d;
         sel_q           <= sel_d;
         pix_cnt_q       <= pix_cnt_d;
         r_q             <= r_d;
         g_q             <= g_d;
         fb_we_q         <= fb_we_d;
         fb_addr_q       <= fb_addr_d;
         fb_data_q       <= fb_data_d;
         frame_done_q    <= frame_done_d;
         frame_pending_q <= frame_pending_d;
         hdr_err_q       <= hdr_err_d;
      end
   end

   assign ftdi_rd_n     = rd_n_q;
   assign ftdi_oe_n     = oe_n_q;
   assign fb_we         = fb_we_q;
   assign fb_addr       = fb_addr_q;
   assign fb_data       = fb_data_q;
   assign frame_done    = frame_done_q;
   assign frame_pending = frame_pending_q;
   assign hdr_err_cnt   = hdr_err_q;

   a_rd_implies_oe: assert property (@(posedge clk) disable iff (rst) !ftdi_rd_n |-> !ftdi_oe_n);
   a_done_with_we:  assert property (@(posedge clk) disable iff (rst) frame_done |-> fb_we);

endmodule

// File: tb/tb_ftdi_frame_rx.sv
// Bench for ftdi_frame_rx: FTDI FIFO source model, byte-stream reference model
// feeding a write scoreboard, and a monitor checking writes and handshake order.
module tb_ftdi_frame_rx;

   localparam int unsigned COLS   = 4;
   localparam int unsigned ROWS   = 2;
   localparam int unsigned ADDR_W = 3;
   localparam int          NPIX   = COLS * ROWS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        ftdi_data;
   logic              ftdi_rxf_n;
   logic              ftdi_rd_n;
   logic              ftdi_oe_n;
   logic              swap_ack;
   logic              fb_we;
   logic [ADDR_W-1:0] fb_addr;
   logic [23:0]       fb_data;
   logic              frame_done;
   logic              frame_pending;
   logic [7:0]        hdr_err_cnt;

   ftdi_frame_rx #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .ftdi_data(ftdi_data), .ftdi_rxf_n(ftdi_rxf_n),
      .ftdi_rd_n(ftdi_rd_n), .ftdi_oe_n(ftdi_oe_n), .swap_ack(swap_ack),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done),
      .frame_pending(frame_pending), .hdr_err_cnt(hdr_err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [23:0]       data;
      bit                done;
      int                cyc;
   } wr_t;

   logic [7:0] src[$];
   wr_t        exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   // reference model state: stream parser over the bytes the FIFO gave away
   bit         m_hunt = 1'b1;
   logic [7:0] m_pix[$];
   int         m_addr = 0;
   int         m_err  = 0;

   bit swap_req = 1'b0;
   bit coll_armed = 1'b0;
   bit coll_hit = 1'b0;
   bit stall_en = 1'b0;
   bit track_fall = 1'b0;
   bit wait_first = 1'b0;
   int first_fall_cyc = 0;
   int first_read_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_byte(input logic [7:0] b, input int c);
      wr_t w;
      if (m_hunt) begin
         if (b == 8'hA5) begin
            m_hunt = 1'b0;
            m_addr = 0;
            m_pix.delete();
         end else if (m_err < 255) begin
            m_err++;
         end
         return 1'b0;
      end
      m_pix.push_back(b);
      if (m_pix.size() < 3) return 1'b0;
      w.addr = ADDR_W'(m_addr);
      w.data = {m_pix[0], m_pix[1], m_pix[2]};
      w.done = (m_addr == NPIX - 1);
      w.cyc  = c + 1;
      exp_q.push_back(w);
      m_pix.delete();
      m_addr++;
      if (w.done) m_hunt = 1'b1;
      return w.done;
   endfunction

   function automatic void model_reset();
      m_hunt = 1'b1;
      m_pix.delete();
      m_addr = 0;
      m_err  = 0;
   endfunction

   // FTDI FIFO: a byte leaves the FIFO on every edge with rd_n=0 and rxf_n=0
   initial begin
      logic rd_now;
      logic new_rxf;
      logic [7:0] b;
      bit d;
      ftdi_rxf_n = 1'b1;
      ftdi_data  = 8'h00;
      swap_ack   = 1'b0;
      forever begin
         @(negedge clk);
         rd_now = (ftdi_rd_n == 1'b0) && (ftdi_rxf_n == 1'b0);
         @(posedge clk);
         #1;
         swap_ack = 1'b0;
         if (rd_now) begin
            b = src.pop_front();
            d = model_byte(b, cyc);
            if (wait_first) begin
               first_read_cyc = cyc;
               wait_first = 1'b0;
            end
            if (d && coll_armed) begin
               swap_ack   = 1'b1;
               coll_armed = 1'b0;
               coll_hit   = 1'b1;
            end
         end
         if (swap_req) begin
            swap_ack = 1'b1;
            swap_req = 1'b0;
         end
         new_rxf = (src.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
         if (track_fall && ftdi_rxf_n && !new_rxf) begin
            first_fall_cyc = cyc;
            track_fall = 1'b0;
            wait_first = 1'b1;
         end
         ftdi_rxf_n = new_rxf;
         ftdi_data  = (src.size() != 0) ? src[0] : 8'($urandom_range(0, 255));
      end
   end

   // monitor: scoreboard pop on every write plus handshake ordering
   logic prev_rd = 1'b1;
   logic prev_oe = 1'b1;
   always @(negedge clk) begin
      wr_t w;
      if (!rst) begin
         if (fb_we) begin
            check("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("wr_addr", fb_addr, w.addr);
               check("wr_data", fb_data, w.data);
               check("wr_done", frame_done, w.done);
               check("wr_cycle", cyc, w.cyc);
            end
         end
         if (frame_done) begin
            check("done_with_we", fb_we, 1);
            done_cnt++;
         end
         if (!ftdi_rd_n && prev_rd) check("oe_cycle_before_rd", {prev_oe, ftdi_oe_n}, 0);
         if (ftdi_oe_n && !prev_oe) check("rd_rises_with_oe", ftdi_rd_n, 1);
         if (frame_pending) check("no_read_while_pending", ftdi_rd_n, 1);
      end
      prev_rd = ftdi_rd_n;
      prev_oe = ftdi_oe_n;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      tick(n);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_done(input int target, input string name);
      int k = 0;
      while (done_cnt < target && k < 3000) begin
         tick(1);
         k++;
      end
      check(name, done_cnt >= target, 1);
      tick(2);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((src.size() != 0 || ftdi_rd_n == 1'b0) && k < 3000) begin
         tick(1);
         k++;
      end
      check(name, (src.size() == 0) && ftdi_rd_n, 1);
      tick(4);
   endtask

   task automatic do_swap();
      int k = 0;
      swap_req = 1'b1;
      while (swap_req && k < 10) begin
         tick(1);
         k++;
      end
      tick(2);
      check("swap_clears_pending", frame_pending, 0);
   endtask

   task automatic push_frame(input bit counting);
      src.push_back(8'hA5);
      for (int i = 0; i < 3 * NPIX; i++)
         src.push_back(counting ? 8'(i + 1) : 8'($urandom_range(0, 255)));
   endtask

   task automatic push_garbage(input int n);
      logic [7:0] g;
      for (int i = 0; i < n; i++) begin
         do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
         src.push_back(g);
      end
   endtask

   initial begin
      int d;
      int snap;
      rst = 1'b1;
      tick(1);
      // reset held with the FIFO offering data
      src.push_back(8'h3C);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("rst_ctrl", {ftdi_rd_n, ftdi_oe_n, fb_we, frame_done, frame_pending}, 5'b11000);
         check("rst_addr_data", {fb_addr, fb_data}, 0);
         check("rst_err", hdr_err_cnt, 0);
      end
      rst = 1'b0;
      model_reset();
      wait_idle("post_reset_drain");
      check("err_single_garbage", hdr_err_cnt, m_err);

      // full counting frame with first-read latency
      do_reset(2);
      d = done_cnt;
      track_fall = 1'b1;
      push_frame(1'b1);
      wait_done(d + 1, "full_frame_done");
      tick(4);
      check("first_read_latency", first_read_cyc - first_fall_cyc, 3);
      check("full_frame_pending", frame_pending, 1);
      check("full_frame_rd_high", {ftdi_rd_n, ftdi_oe_n}, 2'b11);
      check("full_frame_one_done", done_cnt, d + 1);
      do_swap();

      // header hunt then saturation
      do_reset(2);
      d = done_cnt;
      src.push_back(8'h00); src.push_back(8'h12); src.push_back(8'hFF);
      push_frame(1'b0);
      wait_done(d + 1, "hunt_frame_done");
      check("hunt_err", hdr_err_cnt, 3);
      check("hunt_err_model", hdr_err_cnt, m_err);
      do_swap();
      push_garbage(300);
      wait_idle("garbage_drain");
      check("err_saturated", hdr_err_cnt, 255);

      // flow gap after pixel byte 5
      do_reset(2);
      d = done_cnt;
      src.push_back(8'hA5);
      for (int i = 0; i < 5; i++) src.push_back(8'($urandom_range(0, 255)));
      wait_idle("gap_drain");
      for (int i = 0; i < 3; i++) begin
         check("gap_bus_released", {ftdi_rd_n, ftdi_oe_n}, 2'b11);
         tick(1);
      end
      for (int i = 5; i < 3 * NPIX; i++) src.push_back(8'($urandom_range(0, 255)));
      wait_done(d + 1, "gap_frame_done");
      do_swap();

      // two frames back to back: overshoot takes frame 2 header, then stall
      d = done_cnt;
      snap = m_err;
      push_frame(1'b0);
      push_frame(1'b0);
      wait_done(d + 1, "stall_frame1_done");
      tick(20);
      check("stall_one_overshoot", src.size(), 3 * NPIX);
      check("stall_pending", frame_pending, 1);
      check("stall_rd_high", ftdi_rd_n, 1);
      check("stall_no_extra_done", done_cnt, d + 1);
      do_swap();
      wait_done(d + 2, "stall_frame2_done");
      check("stall_err_unchanged", hdr_err_cnt, snap);
      do_swap();
      do_swap();

      // reset after 10 pixel bytes
      src.push_back(8'hA5);
      for (int i = 0; i < 10; i++) src.push_back(8'($urandom_range(0, 255)));
      wait_idle("partial_drain");
      do_reset(2);
      d = done_cnt;
      push_frame(1'b0);
      wait_done(d + 1, "after_reset_done");
      tick(10);
      check("after_reset_one_done", done_cnt, d + 1);
      do_swap();

      // swap_ack coinciding with the final write is ignored
      d = done_cnt;
      coll_armed = 1'b1;
      push_frame(1'b0);
      wait_done(d + 1, "collision_done");
      tick(10);
      check("collision_seen", coll_hit, 1);
      check("collision_pending_kept", frame_pending, 1);
      do_swap();

      // randomized frames with garbage and FIFO stalls
      stall_en = 1'b1;
      for (int f = 0; f < 6; f++) begin
         d = done_cnt;
         push_garbage($urandom_range(0, 5));
         push_frame(1'b0);
         wait_done(d + 1, "rand_frame_done");
         tick($urandom_range(0, 8));
         check("rand_err", hdr_err_cnt, m_err);
         do_swap();
      end
      stall_en = 1'b0;
      wait_idle("final_drain");
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
